controlador_teclado: RTL

Keyboard-side controller for the memory-mapped keyboard register. Receives PS/2 frames, decodes make/break/extended prefixes into key events, buffers them in a small FIFO and sequences them into the keyboard register through its keyboard write-enable port. Writes happen only when the processor has consumed the previous event (register bit 31 clear), and never in a cycle the processor itself writes the register.

---
 rtl/teclado_pkg.sv | 18 +
 rtl/ps2_rx.sv | 67 ++++++
 rtl/controlador_teclado.sv | 90 +++++++++
 3 files changed

// File: rtl/teclado_pkg.sv
// teclado_pkg: shared constants, event word layout and state types for the
// PS/2 keyboard controller.
package teclado_pkg;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int EV_BRK  = 8;
    localparam int EV_EXT  = 9;
    localparam int EV_PEND = 31;
    typedef enum logic [1:0] {IDLE, PRE_E0, PRE_F0, PRE_E0F0} dec_state_t;
    typedef enum logic {WB_IDLE, WB_ISSUE} wb_state_t;
    function automatic logic [31:0] make_event(input logic ext, input logic brk, input logic [7:0] code);
        logic [31:0] w;
        w = {24'd0, code};
        w[EV_EXT] = ext;
        w[EV_BRK] = brk;
        return w;
    endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver with input synchronisers, clock glitch filter,
// framing/odd-parity check and inter-edge timeout.
module ps2_rx #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       error
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [1:0] clk_s, dat_s;
    logic filt, settle, fall, ok;
    logic [FW-1:0] fcnt;
    logic [3:0] bits;
    logic [9:0] sh;
    logic [TW-1:0] tcnt;
    assign settle = (clk_s[1] != filt) && (fcnt == FW'(FILTER_LEN - 1));
    assign fall = settle && !clk_s[1];
    // sh holds start, 8 data bits and parity; the stop bit is the live sample
    assign ok = !sh[0] && dat_s[1] && ^sh[9:1];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            clk_s <= 2'b11;
            dat_s <= 2'b11;
            filt  <= 1'b1;
            fcnt  <= '0;
            bits  <= '0;
            sh    <= '0;
            tcnt  <= '0;
            data  <= '0;
            valid <= 1'b0;
            error <= 1'b0;
        end else begin
            clk_s <= {clk_s[0], ps2_clk};
            dat_s <= {dat_s[0], ps2_data};
            fcnt  <= (clk_s[1] != filt && !settle) ? fcnt + 1'b1 : '0;
            if (settle)
                filt <= clk_s[1];
            valid <= 1'b0;
            error <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                if (bits == 4'd10) begin
                    bits  <= '0;
                    valid <= ok;
                    error <= !ok;
                    data  <= sh[8:1];
                end else begin
                    bits <= bits + 4'd1;
                    sh   <= {dat_s[1], sh[9:1]};
                end
            end else if (bits != 4'd0) begin
                if (tcnt == TW'(TIMEOUT - 1)) begin
                    bits  <= '0;
                    tcnt  <= '0;
                    error <= 1'b1;
                end else
                    tcnt <= tcnt + 1'b1;
            end
        end
endmodule

// File: rtl/controlador_teclado.sv
// controlador_teclado: decodes PS/2 scan codes into key events, buffers them and
// writes them into the keyboard register whenever the processor has consumed the last one.
module controlador_teclado
    import teclado_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 5000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    input  logic        WE_Procesador,
    input  logic [31:0] REG_OUT,
    output logic        WE_Teclado,
    output logic [31:0] DATA_OUT,
    output logic        ERROR,
    output logic        OVERFLOW
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [7:0] rx_data;
    logic rx_valid, rx_err, push, full, pop, accept, unused;
    logic [31:0] ev;
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr, rd;
    logic [CW-1:0] count;
    dec_state_t dec;
    wb_state_t wb;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) rx (
        .clk(CLK), .rst(RESET), .ps2_clk(PS2_CLK), .ps2_data(PS2_DATA),
        .data(rx_data), .valid(rx_valid), .error(rx_err)
    );

    assign ERROR  = rx_err;
    assign unused = ^REG_OUT[30:0];

    // prefix bytes only advance the decoder; every other byte becomes an event
    always_comb begin
        push = rx_valid && !(dec == IDLE && (rx_data == PS2_EXT || rx_data == PS2_BRK))
                        && !(dec == PRE_E0 && rx_data == PS2_BRK);
        ev   = make_event(dec == PRE_E0 || dec == PRE_E0F0, dec == PRE_F0 || dec == PRE_E0F0, rx_data);
    end

    always_ff @(posedge CLK or posedge RESET)
        if (RESET)
            dec <= IDLE;
        else if (rx_err)
            dec <= IDLE;
        else if (rx_valid)
            dec <= (dec == IDLE && rx_data == PS2_EXT)   ? PRE_E0 :
                   (dec == IDLE && rx_data == PS2_BRK)   ? PRE_F0 :
                   (dec == PRE_E0 && rx_data == PS2_BRK) ? PRE_E0F0 : IDLE;

    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign full   = count == CW'(FIFO_DEPTH);
    assign pop    = WE_Teclado;
    assign accept = push && (!full || pop);

    always_ff @(posedge CLK)
        if (accept)
            mem[wr] <= ev;

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            wr       <= '0;
            rd       <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            wr       <= wr + AW'(accept);
            rd       <= rd + AW'(pop);
            count    <= count + CW'(accept) - CW'(pop);
            OVERFLOW <= (OVERFLOW && !WE_Procesador) || (push && !accept);
        end

    // the processor always wins the register; a pending bit set behind our back aborts the issue
    assign WE_Teclado = wb == WB_ISSUE && !WE_Procesador && !REG_OUT[EV_PEND];
    assign DATA_OUT   = wb == WB_ISSUE ? mem[rd] : '0;

    always_ff @(posedge CLK or posedge RESET)
        if (RESET)
            wb <= WB_IDLE;
        else if (wb == WB_IDLE)
            wb <= (count != '0 && !REG_OUT[EV_PEND]) ? WB_ISSUE : WB_IDLE;
        else if (WE_Teclado || REG_OUT[EV_PEND])
            wb <= WB_IDLE;
endmodule
